clint_timer: RTL and testbench
==============================

# clint_timer

Core-local interrupt source (CLINT) for the pipeline. It holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` software-interrupt bit, all reachable over a simple memory-mapped request/response port. It drives the registered `trint`, `swint` and `exint` level inputs of the CSR stage, which samples them into `mip` every cycle.

## Interface
Parameters:
- `TICK_DIV`, default 1: number of clk cycles per `mtime` increment; legal range 1..65535.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset. All state clears immediately on assertion; release is synchronous to `clk`.
- `req_valid` in 1: bus request strobe. A request is accepted every cycle in which this is high; there is no stall.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte offset inside the CLINT window; bits [2:0] are ignored.
- `req_wdata` in 64: write data.
- `req_strb` in 8: byte enables for writes.
- `resp_valid` out 1: pulses high exactly one cycle after each accepted request.
- `resp_rdata` out 64: read data, valid while `resp_valid` is high; 0 for writes and for unmapped offsets.
- `exint_in` in 1: raw external-interrupt line from the platform.
- `trint` out 1: timer interrupt pending, to the CSR stage.
- `swint` out 1: software interrupt pending, to the CSR stage.
- `exint` out 1: external interrupt pending, to the CSR stage.

## Operation
- Register map (offsets compared on bits [15:3]):
  - 0x0000 `msip`: only bit 0 is implemented; the other bits read 0.
  - 0x4000 `mtimecmp`: 64 bits.
  - 0xBFF8 `mtime`: 64 bits.
  - Any other offset: reads return 0, writes are ignored, and a response is still generated.
- Writes: byte lane i is written only when `req_strb[i]` is set; unselected lanes keep their value.
- Prescaler: a counter `div_cnt` counts 0..TICK_DIV-1 and wraps. The increment `tick` is asserted in the cycle in which `div_cnt == TICK_DIV-1`. With TICK_DIV=1, `tick` is asserted every cycle.
- `mtime`:
  - Increments by 1 on `tick`; 64-bit wrap from all-ones to 0.
  - A bus write to `mtime` in the same cycle has priority over the increment: the written value is stored and that cycle's increment is lost.
  - A write to `mtime` does not reset `div_cnt`.
- `trint` register is loaded with (`mtime_next` >= `mtimecmp_next`), using an unsigned 64-bit compare on the values being loaded this cycle.
- `swint` register is loaded with `msip_next`.
- `exint` follows `exint_in`; see Configuration.
- Reads return the register value from before any same-cycle update. The read-data register is loaded at the accepting edge.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, `div_cnt` = 0.
  - `trint` = 0, `swint` = 0, `exint` = 0, `resp_valid` = 0, `resp_rdata` = 0.
  - Any synchronizer flops = 0.

## Timing
- Response latency is 1 cycle. Back-to-back requests produce back-to-back responses.
- A write to `mtimecmp` or `msip` at edge N is visible on `trint`/`swint` after edge N; the compare uses the new value.
- Compare example: if `mtime` reaches `mtimecmp` at edge N, `trint` rises after the same edge N.
- Interrupt outputs are levels, not pulses. They stay high until software clears the condition by raising `mtimecmp` or clearing `msip`.
- Wrap: when `mtime` wraps to 0 while `mtimecmp` is nonzero, `trint` drops after the wrapping edge.
- Reset asserted mid-transaction: the pending response is dropped (`resp_valid` = 0) and the prescaler phase restarts from 0.

## Configuration
- `CLINT_EXINT_SYNC_EN`:
  - Defined: `exint_in` passes through a two-flop synchronizer, so `exint` lags `exint_in` by 2 cycles.
  - Undefined: `exint` is a single register of `exint_in`, a 1-cycle lag, for inputs already synchronous to `clk`.

## Test plan
- Reset release with TICK_DIV=1, no requests → `trint`=`swint`=`exint`=0; reading 0xBFF8 at cycle 10 after reset returns 10 (±1 per the read-before-update rule, fixed by the bench).
- Write `mtimecmp`=20, then poll → `trint` rises in the cycle `mtime` becomes 20. Then write `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF → `trint` falls 1 cycle after the write.
- Write 0x0000 with wdata=1, strb=0x01 → `swint`=1 next cycle. Write wdata=0 with strb=0x00 → `swint` stays 1. Read 0x0000 → 1.
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE with `mtimecmp`=5 → `trint`=1, wraps to 0 two ticks later, then `trint`=0. Partial write with strb=0x0F updates only the low word.
- TICK_DIV=4: `mtime` advances once per 4 clocks. Reading unmapped 0x1234 → `resp_valid` after 1 cycle, `rdata`=0.
- Pulse `exint_in` high for 3 cycles → `exint` is high for 3 cycles with a delay of 2 cycles (with the macro) or 1 cycle (without).

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: CLINT mtime/mtimecmp/msip block driving registered trint/swint/exint levels.
// Define CLINT_EXINT_SYNC_EN to route exint_in through a two-flop synchronizer.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strb,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    input  logic        exint_in,
    output logic        trint,
    output logic        swint,
    output logic        exint
);
    localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);

    logic [15:0] r_div_cnt;
    logic [63:0] r_mtime, r_mtimecmp, r_resp_rdata;
    logic        r_msip, r_trint, r_swint, r_exint, r_resp_valid;
    logic        w_tick, w_wr, w_sel_msip, w_sel_cmp, w_sel_time, w_msip_next, w_unused;
    logic [63:0] w_mask, w_mtime_next, w_mtimecmp_next, w_rdata;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_mask
            assign w_mask[8*i +: 8] = {8{req_strb[i]}};
        end
    endgenerate

    assign w_unused        = ^req_addr[2:0];
    assign w_tick          = r_div_cnt == DIV_MAX;
    assign w_wr            = req_valid && req_write;
    assign w_sel_msip      = req_addr[15:3] == 13'h0000;
    assign w_sel_cmp       = req_addr[15:3] == 13'h0800;
    assign w_sel_time      = req_addr[15:3] == 13'h17FF;
    // A bus write to mtime wins over that cycle's tick
    assign w_mtime_next    = (w_wr && w_sel_time) ? (r_mtime & ~w_mask) | (req_wdata & w_mask)
                                                  : r_mtime + 64'(w_tick);
    assign w_mtimecmp_next = (w_wr && w_sel_cmp) ? (r_mtimecmp & ~w_mask) | (req_wdata & w_mask)
                                                 : r_mtimecmp;
    assign w_msip_next     = (w_wr && w_sel_msip && req_strb[0]) ? req_wdata[0] : r_msip;
    assign w_rdata         = w_sel_msip ? {63'd0, r_msip} :
                             w_sel_cmp  ? r_mtimecmp :
                             w_sel_time ? r_mtime : 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt    <= 16'd0;
            r_mtime      <= 64'd0;
            r_mtimecmp   <= '1;
            r_msip       <= 1'b0;
            r_trint      <= 1'b0;
            r_swint      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
        end else begin
            r_div_cnt    <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
            r_mtime      <= w_mtime_next;
            r_mtimecmp   <= w_mtimecmp_next;
            r_msip       <= w_msip_next;
            r_trint      <= w_mtime_next >= w_mtimecmp_next;
            r_swint      <= w_msip_next;
            r_resp_valid <= req_valid;
            r_resp_rdata <= (req_valid && !req_write) ? w_rdata : 64'd0;
        end
    end

`ifdef CLINT_EXINT_SYNC_EN
    logic r_exint_meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exint_meta <= 1'b0;
            r_exint      <= 1'b0;
        end else begin
            r_exint_meta <= exint_in;
            r_exint      <= r_exint_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_exint <= 1'b0;
        else       r_exint <= exint_in;
    end
`endif

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign trint      = r_trint;
    assign swint      = r_swint;
    assign exint      = r_exint;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard bench for clint_timer with TICK_DIV=1 and TICK_DIV=4 instances on a shared bus.
module tb_clint_timer;
`ifdef CLINT_EXINT_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk, reset, req_valid, req_write, exint_in;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        resp_valid1, trint1, swint1, exint1;
    logic        resp_valid4, trint4, swint4, exint4;
    logic [63:0] rdata1, rdata4;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e4;
        bit          c4;
        int          due;
    } exp_t;
    exp_t q[$];

    int          cyc = 0, chk = 0, pass = 0, r0 = 0, we = 0;
    logic [63:0] wv = 64'd0;

    clint_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid1), .resp_rdata(rdata1), .exint_in(exint_in),
        .trint(trint1), .swint(swint1), .exint(exint1)
    );
    clint_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid4), .resp_rdata(rdata4), .exint_in(exint_in),
        .trint(trint4), .swint(swint4), .exint(exint4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mtime value held after edge e, from the last full write (wv at edge we) and the reset edge r0
    function automatic logic [63:0] m1(input int e);
        return wv + 64'(e - we);
    endfunction
    function automatic logic [63:0] m4(input int e);
        return wv + 64'((e - r0) / 4 - (we - r0) / 4);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t x;
                x = q.pop_front();
                chk++;
                if (resp_valid1 !== 1'b1 || rdata1 !== x.e1)
                    $display("FAIL resp1: valid=%b rdata=%h want valid=1 rdata=%h", resp_valid1, rdata1, x.e1);
                else pass++;
                chk++;
                if (resp_valid4 !== 1'b1 || (x.c4 && rdata4 !== x.e4))
                    $display("FAIL resp4: valid=%b rdata=%h want valid=1 rdata=%h", resp_valid4, rdata4, x.e4);
                else pass++;
            end else if (resp_valid1 !== 1'b0 || resp_valid4 !== 1'b0) begin
                chk++;
                $display("FAIL spurious_resp: valid1=%b valid4=%b want 0", resp_valid1, resp_valid4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit w, input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                       input logic [63:0] e1, input logic [63:0] e4, input bit c4);
        exp_t x;
        x.e1 = e1; x.e4 = e4; x.c4 = c4; x.due = cyc + 1;
        q.push_back(x);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_strb = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        chk++;
        if (resp_valid1 !== 1'b0 || rdata1 !== 64'd0)
            $display("FAIL reset_resp: valid=%b rdata=%h want 0/0", resp_valid1, rdata1);
        else pass++;
        reset = 1'b0; r0 = cyc; we = cyc; wv = 64'd0;
        repeat (10) step();
        chk++;
        if ({trint1, swint1, exint1, trint4, swint4, exint4} !== 6'b0)
            $display("FAIL reset_irq: got %b want 000000", {trint1, swint1, exint1, trint4, swint4, exint4});
        else pass++;
        req(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'd10, 64'd2, 1'b1);
    endtask

    task automatic test_timer_cmp();
        bit rose = 1'b0;
        req(1'b1, 16'h4000, 64'd20, 8'hFF, 64'd0, 64'd0, 1'b0);
        chk++;
        if (trint1 !== 1'b0) $display("FAIL cmp_after_write: got %b want 0", trint1);
        else pass++;
        for (int i = 0; i < 15; i++) begin
            step();
            chk++;
            if (trint1 !== (m1(cyc) >= 64'd20))
                $display("FAIL cmp_poll: mtime=%0d trint=%b want %b", m1(cyc), trint1, m1(cyc) >= 64'd20);
            else pass++;
            if (trint1) rose = 1'b1;
        end
        chk++;
        if (rose !== 1'b1) $display("FAIL cmp_rose: got %b want 1", rose);
        else pass++;
        req(1'b1, 16'h4000, ONES, 8'hFF, 64'd0, 64'd0, 1'b0);
        chk++;
        if (trint1 !== 1'b0) $display("FAIL cmp_clear: got %b want 0", trint1);
        else pass++;
    endtask

    task automatic test_swint();
        req(1'b1, 16'h0000, 64'd1, 8'h01, 64'd0, 64'd0, 1'b0);
        chk++;
        if (swint1 !== 1'b1 || swint4 !== 1'b1) $display("FAIL sw_set: got %b%b want 11", swint1, swint4);
        else pass++;
        req(1'b1, 16'h0000, 64'd0, 8'h00, 64'd0, 64'd0, 1'b0);
        chk++;
        if (swint1 !== 1'b1) $display("FAIL sw_nostrb: got %b want 1", swint1);
        else pass++;
        req(1'b1, 16'h0000, ONES, 8'hFF, 64'd0, 64'd0, 1'b0);
        req(1'b0, 16'h0000, 64'd0, 8'h00, 64'd1, 64'd1, 1'b1);
        req(1'b1, 16'h0000, 64'd0, 8'h01, 64'd0, 64'd0, 1'b0);
        chk++;
        if (swint1 !== 1'b0 || swint4 !== 1'b0) $display("FAIL sw_clear: got %b%b want 00", swint1, swint4);
        else pass++;
    endtask

    task automatic test_tick4();
        for (int i = 0; i < 9; i++) req(1'b0, 16'hBFF8, 64'd0, 8'h00, m1(cyc), m4(cyc), 1'b1);
    endtask

    task automatic test_unmapped();
        req(1'b0, 16'h1234, 64'd0, 8'h00, 64'd0, 64'd0, 1'b1);
        req(1'b1, 16'h1234, 64'd5, 8'hFF, 64'd0, 64'd0, 1'b0);
        req(1'b0, 16'h4007, 64'd0, 8'h00, ONES, ONES, 1'b1);
    endtask

    task automatic test_wrap();
        req(1'b1, 16'h4000, 64'd5, 8'hFF, 64'd0, 64'd0, 1'b0);
        chk++;
        if (trint1 !== 1'b1) $display("FAIL wrap_cmp5: got %b want 1", trint1);
        else pass++;
        req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 64'd0, 1'b0);
        wv = 64'hFFFF_FFFF_FFFF_FFFE; we = cyc;
        for (int k = 0; k < 9; k++) begin
            chk++;
            if (trint1 !== (m1(cyc) >= 64'd5))
                $display("FAIL wrap_trint: mtime=%h trint=%b want %b", m1(cyc), trint1, m1(cyc) >= 64'd5);
            else pass++;
            step();
        end
        req(1'b0, 16'hBFF8, 64'd0, 8'h00, m1(cyc), m4(cyc), 1'b1);
        req(1'b1, 16'h4000, ONES, 8'hFF, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic test_partial();
        req(1'b1, 16'hBFF8, 64'h1111_2222_3333_4444, 8'hFF, 64'd0, 64'd0, 1'b0);
        wv = 64'h1111_2222_3333_4444; we = cyc;
        req(1'b1, 16'hBFF8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 64'd0, 64'd0, 1'b0);
        wv = 64'h1111_2222_CCCC_DDDD; we = cyc;
        req(1'b0, 16'hBFF8, 64'd0, 8'h00, m1(cyc), m4(cyc), 1'b1);
        req(1'b1, 16'h4000, 64'd0, 8'hF0, 64'd0, 64'd0, 1'b0);
        chk++;
        if (trint1 !== 1'b1) $display("FAIL partial_cmp_trint: got %b want 1", trint1);
        else pass++;
        req(1'b0, 16'h4000, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b1);
        req(1'b1, 16'h4000, ONES, 8'hFF, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic test_exint();
        exint_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk++;
            if (exint1 !== (i >= LAG && i < LAG + 3) || exint4 !== exint1)
                $display("FAIL exint: cycle %0d got %b%b want %b", i, exint1, exint4, i >= LAG && i < LAG + 3);
            else pass++;
            if (i == 3) exint_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8;
        step();
        req_valid = 1'b0;
        chk++;
        if (resp_valid1 !== 1'b1) $display("FAIL mid_pending: got %b want 1", resp_valid1);
        else pass++;
        reset = 1'b1;
        #1;
        chk++;
        if (resp_valid1 !== 1'b0 || rdata1 !== 64'd0 || resp_valid4 !== 1'b0)
            $display("FAIL mid_drop: valid=%b rdata=%h want 0/0", resp_valid1, rdata1);
        else pass++;
        repeat (2) step();
        reset = 1'b0; r0 = cyc; we = cyc; wv = 64'd0;
        repeat (5) step();
        req(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'd5, 64'd1, 1'b1);
        req(1'b0, 16'h4000, 64'd0, 8'h00, ONES, ONES, 1'b1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
        req_wdata = 64'd0; req_strb = 8'h00; exint_in = 1'b0;
        test_reset();
        test_timer_cmp();
        test_swint();
        test_tick4();
        test_unmapped();
        test_wrap();
        test_partial();
        test_exint();
        test_reset_mid();
        repeat (3) step();
        chk++;
        if (q.size() !== 0) $display("FAIL missing_resp: %0d outstanding want 0", q.size());
        else pass++;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
